// File: rtl/pay_engine_if.sv
// Bus between the mode controller/coin front end and the payment engine.
// The engine takes the slave side; the controller or bench takes the master side.
interface pay_engine_if;
  logic [3:0]  mode;
  logic [7:0]  price;
  logic        coin_1;
  logic        coin_5;
  logic        coin_10;
  logic        finish;
  logic        fail;
  logic [7:0]  paid;
  logic [7:0]  change;
  logic        change_valid;
  logic [5:0]  time_left;
  logic [15:0] sale_total;
  logic [7:0]  sale_count;

  modport master (
    output mode, price, coin_1, coin_5, coin_10,
    input  finish, fail, paid, change, change_valid, time_left, sale_total, sale_count
  );

  modport slave (
    input  mode, price, coin_1, coin_5, coin_10,
    output finish, fail, paid, change, change_valid, time_left, sale_total, sale_count
  );
endinterface

// File: rtl/pay_engine.sv
// Vending machine payment engine: collects coins against a latched price,
// signals finish/fail with change or refund, and keeps saturating sales totals.
module pay_engine #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  pay_engine_if.slave bus
);

  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0]     TIMEOUT   = 6'(TIMEOUT_S);
  localparam logic [3:0]     M_PAY     = 4'b0010;
  localparam logic [3:0]     M_SUCCESS = 4'b0110;
  localparam logic [3:0]     M_FAILURE = 4'b0111;
  localparam logic [3:0]     M_CLEAR   = 4'b1110;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, REFUND} state_t;

  state_t        state;
  logic [7:0]    price_r;
  logic [PW-1:0] presc;
  logic          finish_r;
  logic          fail_r;
  logic [7:0]    paid_r;
  logic [7:0]    change_r;
  logic          change_valid_r;
  logic [5:0]    time_left_r;
  logic [15:0]   sale_total_r;
  logic [7:0]    sale_count_r;

  logic [4:0]    coin_sum;
  logic [8:0]    paid_sum;
  logic [7:0]    paid_n;
  logic          tick;
  logic [16:0]   total_sum;
  logic [8:0]    count_sum;
  logic          hold_mode;

  // Simultaneous pulses all count; the widened sums make saturation a carry test.
  assign coin_sum  = {4'd0, bus.coin_1} + (bus.coin_5 ? 5'd5 : 5'd0) + (bus.coin_10 ? 5'd10 : 5'd0);
  assign paid_sum  = {1'b0, paid_r} + {4'd0, coin_sum};
  assign paid_n    = paid_sum[8] ? 8'hFF : paid_sum[7:0];
  assign tick      = (presc == PRESC_MAX);
  assign total_sum = {1'b0, sale_total_r} + {9'd0, price_r};
  assign count_sum = {1'b0, sale_count_r} + 9'd1;
  assign hold_mode = (bus.mode == M_PAY) || (bus.mode == M_SUCCESS) || (bus.mode == M_FAILURE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      price_r        <= '0;
      presc          <= '0;
      finish_r       <= 1'b0;
      fail_r         <= 1'b0;
      paid_r         <= '0;
      change_r       <= '0;
      change_valid_r <= 1'b0;
      time_left_r    <= '0;
      sale_total_r   <= '0;
      sale_count_r   <= '0;
    end else begin
      finish_r <= 1'b0;
      fail_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mode == M_PAY) begin
            price_r     <= bus.price;
            paid_r      <= '0;
            presc       <= '0;
            time_left_r <= TIMEOUT;
            state       <= COLLECT;
          end else if (bus.mode == M_CLEAR) begin
            sale_total_r <= '0;
            sale_count_r <= '0;
          end
        end
        COLLECT: begin
          paid_r <= paid_n;
          if (bus.mode != M_PAY) begin
            change_r       <= paid_n;
            change_valid_r <= 1'b1;
            state          <= REFUND;
          end else if (paid_n >= price_r) begin
            finish_r       <= 1'b1;
            change_r       <= paid_n - price_r;
            change_valid_r <= 1'b1;
            sale_total_r   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            sale_count_r   <= count_sum[8] ? 8'hFF : count_sum[7:0];
            state          <= DONE;
          end else if (coin_sum != 5'd0) begin
            time_left_r <= TIMEOUT;
            presc       <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              if (time_left_r == 6'd1) begin
                fail_r         <= 1'b1;
                change_r       <= paid_n;
                change_valid_r <= 1'b1;
                state          <= REFUND;
              end else begin
                time_left_r <= time_left_r - 6'd1;
              end
            end
          end
        end
        DONE, REFUND: begin
          if (!hold_mode) begin
            paid_r         <= '0;
            change_r       <= '0;
            change_valid_r <= 1'b0;
            time_left_r    <= '0;
            state          <= IDLE;
            if (bus.mode == M_CLEAR) begin
              sale_total_r <= '0;
              sale_count_r <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.finish       = finish_r;
  assign bus.fail         = fail_r;
  assign bus.paid         = paid_r;
  assign bus.change       = change_r;
  assign bus.change_valid = change_valid_r;
  assign bus.time_left    = time_left_r;
  assign bus.sale_total   = sale_total_r;
  assign bus.sale_count   = sale_count_r;

endmodule
